// File: rtl/shift_unit_if.sv
// Handshake and data bundle for shift_unit.
// The consumer side (master) drives requests; the unit (slave) returns results.
interface shift_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             busy;

  modport master (
    output in_valid, op, a, b, flush, out_ready,
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  in_valid, op, a, b, flush, out_ready,
    output in_ready, out_valid, out, busy
  );
endinterface

// File: rtl/shift_unit.sv
// Multi-cycle barrel-less shifter: moves up to STEP bits per BUSY cycle (SLL/SRL/SRA/ROR).
// Define SHIFT_UNIT_ROR_EN to build the rotate path; otherwise op 11 behaves as SRL.
module shift_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic clk,
  input  logic rst_n,
  shift_unit_if.slave bus
);
  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] w_shifted;
  logic [SW-1:0]    r_rem;
  logic [SW-1:0]    w_amt;
  logic [SW-1:0]    w_shamt;
  logic [1:0]       r_op;
  logic             w_accept;
  logic             w_unusedB;

  assign w_shamt   = bus.b[SW-1:0];
  assign w_unusedB = ^bus.b[WIDTH-1:SW];
  assign w_accept  = (r_state == IDLE) && bus.in_valid && !bus.flush;
  assign w_amt     = (r_rem < SW'(STEP)) ? r_rem : SW'(STEP);

`ifdef SHIFT_UNIT_ROR_EN
  logic [SW:0] w_rorBack;
  assign w_rorBack = (SW+1)'(WIDTH) - {1'b0, w_amt};
`endif

  // The working register keeps a's sign bit in place, so SRA can reuse its own MSB as fill.
  always_comb begin
    w_shifted = r_work >> w_amt;
    case (r_op)
      2'b00: w_shifted = r_work << w_amt;
      2'b10: w_shifted = $signed(r_work) >>> w_amt;
`ifdef SHIFT_UNIT_ROR_EN
      2'b11: w_shifted = (r_work >> w_amt) | (r_work << w_rorBack);
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (bus.flush) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: if (bus.in_valid) w_next = (w_shamt == '0) ? DONE : BUSY;
        BUSY: if (r_rem == w_amt) w_next = DONE;
        DONE: if (bus.out_ready) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work <= '0;
      r_rem  <= '0;
      r_op   <= 2'b00;
    end else if (bus.flush) begin
      r_work <= '0;
      r_rem  <= '0;
    end else if (w_accept) begin
      r_work <= bus.a;
      r_rem  <= w_shamt;
      r_op   <= bus.op;
    end else if (r_state == BUSY) begin
      r_work <= w_shifted;
      r_rem  <= r_rem - w_amt;
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.out       = r_work;
endmodule
